// File: rtl/riscv_pkg.sv
// Shared loader types: FSM state encoding and word packing geometry.
// No logic; no latency; no flow control.
// Imported by the loader and its byte-packing sub-block.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into one instruction word.
// Latency: byte visible in word one cycle after byte_en; word_full rises with the last byte.
// No backpressure of its own: the parent gates byte_en with its ready.
module word_assembler
    import riscv_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        byte_en,
    input  logic [7:0]                  byte_data,
    output logic [BYTE_IDX_W-1:0]       byte_idx,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_full
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx  <= '0;
            word      <= '0;
            word_full <= 1'b0;
        end else if (byte_en) begin
            word[8*byte_idx +: 8] <= byte_data;
            byte_idx              <= byte_idx + 1'b1;
            word_full             <= (byte_idx == LAST_IDX);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory one word at a time, holding the core in reset.
// Latency: 4 RECV cycles + 1 WRITE cycle per word with byte_valid held; done 5N cycles after start.
// Backpressure: byte_ready is low outside RECV, so the source holds its byte during WRITE/IDLE/DONE.
module imem_loader
    import riscv_pkg::*;
#(
    parameter  int IMEM_DEPTH = 32,
    localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    loader_state_t         state, state_nxt;
    logic [ADDR_W:0]       count;
    logic [ADDR_W-1:0]     addr;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic                  word_full;
    logic                  byte_acc;
    logic                  last_byte;
    logic                  last_word;
    logic                  len_ok;
    logic                  start_window;
    logic                  load_go;

    assign byte_ready   = (state == RECV);
    assign byte_acc     = byte_valid && byte_ready;
    assign last_byte    = byte_acc && (byte_idx == LAST_IDX);
    assign last_word    = ({1'b0, addr} == count - 1'b1);
    assign len_ok       = (load_words != '0) && (load_words <= (ADDR_W+1)'(IMEM_DEPTH));
    assign start_window = (state == IDLE) || (state == DONE);
    assign load_go      = start && start_window && len_ok;

    // Address and data come straight from registers, so they are stable for the whole strobe.
    assign imem_we   = (state == WRITE) && word_full;
    assign imem_addr = addr;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (load_go),
        .byte_en   (byte_acc),
        .byte_data (byte_data),
        .byte_idx  (byte_idx),
        .word      (imem_wdata),
        .word_full (word_full)
    );

    always_comb begin
        state_nxt  = state;
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load_go) state_nxt = RECV;
            end
            RECV: begin
                busy = 1'b1;
                if (last_byte) state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                state_nxt = last_word ? DONE : RECV;
            end
            DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
                if (load_go) state_nxt = RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            addr     <= '0;
            checksum <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_nxt;
            error <= start && start_window && !len_ok;
            if (load_go) begin
                count    <= load_words;
                addr     <= '0;
                checksum <= '0;
            end else if (imem_we) begin
                checksum <= checksum ^ imem_wdata;
                if (!last_word) addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: writes are scored against a queue by an independent monitor.
module tb_imem_loader;

    localparam int IMEM_DEPTH = 32;
    localparam int ADDR_W     = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   load_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       checksum;

    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  start_cyc   = 0;
    wr_t exp_q[$];
    logic prev_we = 1'b0;

    imem_loader #(.IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_words (load_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        wr_t e;
        if (imem_we) begin
            check("we_back_to_back", {31'b0, prev_we}, 32'd0);
            check("we_during_recv", {31'b0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {27'b0, imem_addr}, {27'b0, e.addr});
                check("write_data", imem_wdata, e.data);
            end
        end
        prev_we = imem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        load_words = 6'(n);
        tick();
        start      = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            tick();
            t++;
        end
        if (!byte_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_ready_timeout: ready 0 after %0d cycles, required 1", t);
        end
        tick();
        if (gap) begin
            byte_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic wait_done(input string name, input int limit);
        int t = 0;
        while (!done && t < limit) begin
            tick();
            t++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done 0 after %0d cycles, required 1", name, limit);
        end
    endtask

    task automatic expect_write(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_words = '0; byte_valid = 1'b0; byte_data = '0;
        tick();
        tick();
        check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_imem_we",    {31'b0, imem_we},    32'd0);
        check("rst_imem_addr",  {27'b0, imem_addr},  32'd0);
        check("rst_imem_wdata", imem_wdata,          32'd0);
        check("rst_core_reset", {31'b0, core_reset}, 32'd1);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_done",       {31'b0, done},       32'd0);
        check("rst_error",      {31'b0, error},      32'd0);
        check("rst_checksum",   checksum,            32'd0);
        reset = 1'b0;
        tick();

        // Rejected lengths from IDLE
        do_start(0);
        check("len0_error", {31'b0, error}, 32'd1);
        check("len0_busy",  {31'b0, busy},  32'd0);
        tick();
        check("len0_error_pulse", {31'b0, error}, 32'd0);
        do_start(33);
        check("len33_error", {31'b0, error}, 32'd1);
        check("len33_busy",  {31'b0, busy},  32'd0);
        tick();
        check("len33_error_pulse", {31'b0, error}, 32'd0);
        check("len33_core_reset",  {31'b0, core_reset}, 32'd1);

        // Nominal two-word load, bytes back to back
        expect_write(0, 32'h0000_0013);
        expect_write(1, 32'h0010_0093);
        do_start(2);
        check("nom_ready_after_start", {31'b0, byte_ready}, 32'd1);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        byte_valid = 1'b0;
        wait_done("nom_done", 50);
        check("nom_done_latency", cyc - start_cyc, 32'd10);
        check("nom_core_reset",   {31'b0, core_reset}, 32'd0);
        check("nom_checksum",     checksum, 32'h0010_0080);

        // Same program again from DONE with byte_valid toggling
        expect_write(0, 32'h0000_0013);
        expect_write(1, 32'h0010_0093);
        do_start(2);
        check("bp_core_reset_reasserted", {31'b0, core_reset}, 32'd1);
        check("bp_checksum_cleared",      checksum, 32'd0);
        check("bp_busy",                  {31'b0, busy}, 32'd1);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_done("bp_done", 50);
        check("bp_checksum", checksum, 32'h0010_0080);

        // Rejected length while DONE
        do_start(0);
        check("done_len0_error", {31'b0, error}, 32'd1);
        check("done_len0_done",  {31'b0, done},  32'd1);
        tick();
        check("done_len0_error_pulse", {31'b0, error}, 32'd0);

        // Single-word reload from DONE
        expect_write(0, 32'hdead_beef);
        do_start(1);
        check("reload_core_reset", {31'b0, core_reset}, 32'd1);
        check("reload_checksum_0", checksum, 32'd0);
        send_word(32'hdead_beef, 1'b0);
        byte_valid = 1'b0;
        wait_done("reload_done", 20);
        check("reload_latency",  cyc - start_cyc, 32'd5);
        check("reload_checksum", checksum, 32'hdead_beef);

        // Reset after two bytes of the second word
        expect_write(0, 32'h4433_2211);
        do_start(2);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'haa, 1'b0);
        send_byte(8'hbb, 1'b0);
        byte_valid = 1'b0;
        reset      = 1'b1;
        tick();
        check("midrst_busy",       {31'b0, busy},       32'd0);
        check("midrst_core_reset", {31'b0, core_reset}, 32'd1);
        check("midrst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("midrst_done",       {31'b0, done},       32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("midrst_no_pending", exp_q.size(), 32'd0);
        expect_write(0, 32'h1234_5678);
        do_start(1);
        send_word(32'h1234_5678, 1'b0);
        byte_valid = 1'b0;
        wait_done("midrst_reload_done", 20);
        check("midrst_reload_checksum", checksum, 32'h1234_5678);

        // Full depth: word i = i; XOR of 0..31 is 0
        for (int i = 0; i < 32; i++) expect_write(i, 32'(i));
        do_start(32);
        for (int i = 0; i < 32; i++) send_word(32'(i), 1'b0);
        byte_valid = 1'b0;
        wait_done("full_done", 400);
        check("full_latency",   cyc - start_cyc, 32'd160);
        check("full_last_addr", {27'b0, imem_addr}, 32'd31);
        check("full_checksum",  checksum, 32'd0);

        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
